// File: rtl/regsfile_mp.sv
// Multi-port register file with write-through bypass, per-register pending
// scoreboard and a one-register-per-cycle clear sweep after reset.
module regsfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  output logic [NRD-1:0]        busy,
  output logic                  init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pending, pending_nx;
  logic                active;
  logic                wr0, wr1, wr1_store, sb_v;

  // A reset cycle in RUN already behaves as INIT so nothing leaks while rst is high.
  assign active    = (state == RUN) && !rst;
  assign init_busy = !active;

  assign wr0       = active && we0 && (waddr0 != '0);
  assign wr1       = active && we1 && (waddr1 != '0);
  assign wr1_store = wr1 && !(wr0 && (waddr0 == waddr1));
  assign sb_v      = active && sb_set && (sb_addr != '0);

  always_comb begin
    state_nx = state;
    if (state == INIT && clr_cnt == '1)
      state_nx = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
      pending <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      if (state == INIT)
        clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr0)
        mem[waddr0] <= wdata0;
      if (wr1_store)
        mem[waddr1] <= wdata1;
    end
  end

  // Clears apply before the set so a new producer issued alongside a write stays pending.
  always_comb begin
    pending_nx = pending;
    if (wr0)
      pending_nx[waddr0] = 1'b0;
    if (wr1)
      pending_nx[waddr1] = 1'b0;
    if (sb_v)
      pending_nx[sb_addr] = 1'b1;
    pending_nx[0] = 1'b0;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              live, hit0, hit1;

    assign ra   = raddr[g*ADDR_W +: ADDR_W];
    assign live = active && re[g] && (ra != '0);
    assign hit0 = wr0 && (waddr0 == ra);
    assign hit1 = wr1 && (waddr1 == ra);

    assign rdata[g*DATA_W +: DATA_W] = !live ? '0 :
                                       hit0  ? wdata0 :
                                       hit1  ? wdata1 : mem[ra];
    assign busy[g] = live && pending[ra] && !hit0 && !hit1;
  end

endmodule

// File: tb/tb_regsfile_mp.sv
// Directed bench for regsfile_mp: init sweep timing, bypass, write priority,
// scoreboard behaviour and reset restarts.
module tb_regsfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, sb_set, init_busy;
  logic [4:0]  waddr0, waddr1, sb_addr;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  re, busy;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regsfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy(busy), .init_busy(init_busy)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        sb;
    logic [4:0]  sba;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic w0, logic [4:0] a0, logic [31:0] d0,
                              logic w1, logic [4:0] a1, logic [31:0] d1,
                              logic [1:0] r, logic [4:0] r0, logic [4:0] r1,
                              logic s, logic [4:0] sa,
                              logic [31:0] x0, logic [31:0] x1, logic [1:0] xb);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.re = r; v.ra0 = r0; v.ra1 = r1;
    v.sb = s; v.sba = sa;
    v.e0 = x0; v.e1 = x1; v.eb = xb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 0; waddr0 = 0; wdata0 = 0;
    we1 = 0; waddr1 = 0; wdata1 = 0;
    re = 0; raddr = 0; sb_set = 0; sb_addr = 0;
  endtask

  // Drives write/sb noise throughout INIT; returns cycles init_busy stayed high
  // and whether any read or busy output was nonzero meanwhile.
  task automatic count_init(output int n, output bit leak);
    n = 0;
    leak = 0;
    while (init_busy && n < 100) begin
      we0 = 1; waddr0 = 5'd1; wdata0 = 32'hFFFF_FFFF;
      we1 = 1; waddr1 = 5'd2; wdata1 = 32'hEEEE_EEEE;
      sb_set = 1; sb_addr = 5'd9;
      re = 2'b11; raddr = {5'd9, 5'd1};
      #1;
      if (rdata !== 64'd0 || busy !== 2'b00) leak = 1;
      n++;
      @(negedge clk);
      #1;
    end
    idle();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    bit bad = 0;
    for (int a = 0; a < 32; a++) begin
      re = 2'b11;
      raddr = {5'(a), 5'(a)};
      #1;
      if (rdata !== 64'd0 || busy !== 2'b00) bad = 1;
    end
    chk({tag, "_all_zero"}, {63'd0, bad}, 64'd0);
    idle();
  endtask

  initial begin
    int  n;
    bit  leak;

    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 0,  2'b11, 5, 5,   0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    vecs[1]  = mk(0, 0,  0,            0, 0, 0,  2'b11, 5, 0,   0, 0,  32'hDEADBEEF, 32'h0,        2'b00);
    vecs[2]  = mk(1, 7,  32'h11,       1, 7, 32'h22, 2'b11, 7, 7, 0, 0, 32'h11,       32'h11,       2'b00);
    vecs[3]  = mk(0, 0,  0,            0, 0, 0,  2'b11, 7, 5,   0, 0,  32'h11,       32'hDEADBEEF, 2'b00);
    vecs[4]  = mk(1, 0,  32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 2'b11, 0, 0, 0, 0, 32'h0, 32'h0,     2'b00);
    vecs[5]  = mk(0, 0,  0,            0, 0, 0,  2'b01, 5, 7,   0, 0,  32'hDEADBEEF, 32'h0,        2'b00);
    vecs[6]  = mk(0, 0,  0,            1, 12, 32'hA5A5, 2'b11, 12, 12, 0, 0, 32'hA5A5,  32'hA5A5,     2'b00);
    vecs[7]  = mk(0, 0,  0,            0, 0, 0,  2'b11, 9, 9,   1, 9,  32'h0,        32'h0,        2'b00);
    vecs[8]  = mk(0, 0,  0,            0, 0, 0,  2'b11, 9, 9,   0, 0,  32'h0,        32'h0,        2'b11);
    vecs[9]  = mk(0, 0,  0,            0, 0, 0,  2'b01, 9, 9,   0, 0,  32'h0,        32'h0,        2'b01);
    vecs[10] = mk(0, 0,  0,            1, 9, 32'h99, 2'b11, 9, 9, 0, 0, 32'h99,       32'h99,       2'b00);
    vecs[11] = mk(0, 0,  0,            0, 0, 0,  2'b11, 9, 9,   0, 0,  32'h99,       32'h99,       2'b00);
    vecs[12] = mk(1, 9,  32'h123,      0, 0, 0,  2'b11, 9, 9,   1, 9,  32'h123,      32'h123,      2'b00);
    vecs[13] = mk(0, 0,  0,            0, 0, 0,  2'b11, 9, 9,   0, 0,  32'h123,      32'h123,      2'b11);
    vecs[14] = mk(0, 0,  0,            0, 0, 0,  2'b11, 0, 0,   1, 0,  32'h0,        32'h0,        2'b00);
    vecs[15] = mk(0, 0,  0,            0, 0, 0,  2'b11, 0, 0,   0, 0,  32'h0,        32'h0,        2'b00);
    vecs[16] = mk(1, 3,  32'h33,       1, 4, 32'h44, 2'b11, 3, 4, 0, 0, 32'h33,       32'h44,       2'b00);
    vecs[17] = mk(0, 0,  0,            0, 0, 0,  2'b11, 4, 3,   0, 0,  32'h44,       32'h33,       2'b00);
    vecs[18] = mk(0, 0,  0,            0, 0, 0,  2'b00, 0, 0,   1, 20, 32'h0,        32'h0,        2'b00);
    vecs[19] = mk(1, 21, 32'h1,        0, 0, 0,  2'b11, 20, 21, 0, 0,  32'h0,        32'h1,        2'b01);

    idle();
    rst = 1;
    repeat (3) @(negedge clk);
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h1234; re = 2'b11; raddr = {5'd3, 5'd3};
    #1;
    chk("reset_init_busy", {63'd0, init_busy}, 64'd1);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_busy", {62'd0, busy}, 64'd0);
    idle();

    rst = 0;
    #1;
    count_init(n, leak);
    chk("init_len", 64'(n), 64'd32);
    chk("init_quiet", {63'd0, leak}, 64'd0);
    chk("run_init_busy", {63'd0, init_busy}, 64'd0);
    check_all_zero("post_init");
    chk("init_ignores_sb", {62'd0, busy}, 64'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
      we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
      re = vecs[i].re; raddr = {vecs[i].ra1, vecs[i].ra0};
      sb_set = vecs[i].sb; sb_addr = vecs[i].sba;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, {vecs[i].e1, vecs[i].e0});
      chk($sformatf("vec%0d_busy", i), {62'd0, busy}, {62'd0, vecs[i].eb});
    end
    @(negedge clk);
    idle();

    // Restart the sweep part-way: clr_cnt reaches 10 after ten edges.
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    count_init(n, leak);
    chk("mid_init_len", 64'(n), 64'd32);
    chk("mid_init_quiet", {63'd0, leak}, 64'd0);
    check_all_zero("mid_init");

    // Reset from RUN with pending registers and a concurrent write.
    sb_set = 1; sb_addr = 5'd9;
    @(negedge clk);
    sb_addr = 5'd20;
    @(negedge clk);
    idle();
    re = 2'b11; raddr = {5'd20, 5'd9};
    #1;
    chk("pend_before_rst", {62'd0, busy}, 64'd3);
    rst = 1;
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'hBAD;
    #1;
    chk("rst_cycle_rdata", rdata, 64'd0);
    chk("rst_cycle_busy", {62'd0, busy}, 64'd0);
    @(negedge clk);
    idle();
    rst = 0;
    #1;
    count_init(n, leak);
    chk("run_rst_len", 64'(n), 64'd32);
    chk("run_rst_quiet", {63'd0, leak}, 64'd0);
    check_all_zero("run_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regsfile_mp.md
REGSFILE_MP -- requirements
Module: regsfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have ports we0/waddr0/wdata0, input, 1/ADDR_W/DATA_W, write port 0 (writeback stage; priority port).
REQ-007 SHALL have ports we1/waddr1/wdata1, input, 1/ADDR_W/DATA_W, write port 1 (secondary: load/CSR return).
REQ-008 SHALL have ports re, raddr, input, NRD/NRD*ADDR_W, per-port read enable and packed read addresses (port i at bits [i*ADDR_W +: ADDR_W]).
REQ-009 SHALL have port rdata, output, NRD*DATA_W, packed combinational read data.
REQ-010 SHALL have ports sb_set/sb_addr, input, 1/ADDR_W, scoreboard: mark register pending (issued, not yet written).
REQ-011 SHALL have port busy, output, NRD, per-read-port pending flag for raddr[i].
REQ-012 SHALL have port init_busy, output, 1, high while the clear sequence runs.

Function
REQ-013 SHALL implement a 2-state FSM: INIT, RUN.
REQ-014 INIT: 1 register cleared to 0 per cycle by counter clr_cnt, 0 -> 2**ADDR_W-1; on final count -> RUN; takes exactly 2**ADDR_W cycles after rst deasserts.
REQ-015 In INIT, SHALL ignore we0/we1/sb_set; rdata = 0 and busy = 0 on all ports; init_busy = 1.
REQ-016 In RUN, init_busy = 0; write on port k when wek=1 and waddrk != 0 -- register 0 never written, always reads 0.
REQ-017 Same-cycle writes to same nonzero address: port 0 value stored, port 1 discarded.
REQ-018 Read port i, RUN: rdata = 0 if re[i]=0 or raddr[i]=0; else wdata0 if we0 and waddr0==raddr[i]; else wdata1 if we1 and waddr1==raddr[i]; else stored value (zero-latency write-through bypass).
REQ-019 Scoreboard: one pending bit per register; bit 0 hardwired 0.
REQ-020 sb_set with sb_addr != 0 SHALL set pending[sb_addr] at next edge.
REQ-021 Write on either port to nonzero address SHALL clear pending[waddr] at next edge.
REQ-022 Simultaneous sb_set and write to same address: set wins (new producer) -- bit is 1 after edge.
REQ-023 busy[i] = pending[raddr[i]] & re[i], except 0 when a same-cycle write to raddr[i] exists (bypass satisfies it).
REQ-024 No output SHALL be registered beyond the FSM, counter, storage and pending bits; all reads are combinational.

Reset
REQ-025 rst=1 at an edge SHALL: FSM -> INIT, clr_cnt -> 0, all pending bits -> 0; init_busy=1, rdata=0, busy=0 during and after rst until RUN.
REQ-026 rst asserted mid-INIT or mid-RUN SHALL restart INIT from count 0; any concurrent write is dropped.
REQ-027 Storage contents need not be initialised by rst itself; the INIT sweep guarantees all zeros on entry to RUN.

Verification
REQ-028 Reset release, defaults -> init_busy=1 for exactly 32 cycles, then 0; read of every address returns 0.
REQ-029 RUN: we0=1,waddr0=5,wdata0=0xDEADBEEF, raddr[0]=5,re[0]=1 same cycle -> rdata[0]=0xDEADBEEF that cycle and after.
REQ-030 we0 and we1 both to addr 7 (0x11, 0x22) -> same-cycle read = 0x11; next cycle stored = 0x11.
REQ-031 Write to addr 0 with 0xFFFFFFFF on both ports -> reads of addr 0 remain 0, busy=0.
REQ-032 sb_set addr 9; next cycle raddr=9,re=1 -> busy=1; we1 to 9 -> busy=0 same cycle, bit clear next; sb_set and we0 to 9 together -> busy=1 afterwards.
REQ-033 rst pulsed at clr_cnt=10 during INIT, and again in RUN with pending bits set -> init_busy high 32 more cycles, all pending 0, writes ignored throughout.
